// File: rtl/mips_pipe_pkg.sv
// Shared types and sizing for the pipelined MIPS datapath.
package mips_pipe_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_e;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage : mips_pipe_pkg

// File: rtl/mem_access_stage.sv
// M stage: turns load/store controls into a req/ack transaction on a
// variable-latency data-memory port, stalling the pipeline until it completes.
module mem_access_stage
    import mips_pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic              RegWriteM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic              RegWriteOutM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallM,
    output logic              AlignErrM,
    output logic              BusErrM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic access, misaligned, start, timeout_hit;

    assign access      = MemReadM | MemWriteM;
    assign misaligned  = ALUOutM[1:0] != 2'b00;
    assign start       = access & ~misaligned;
    assign timeout_hit = cnt_q == CNT_LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     if (mem_ack || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        StallM    = 1'b0;
        AlignErrM = 1'b0;
        BusErrM   = 1'b0;
        ReadDataM = '0;
        unique case (state_q)
            IDLE: begin
                AlignErrM = access & misaligned;
                StallM    = start;
            end
            REQ:  StallM = 1'b1;
            DONE: begin
                ReadDataM = rdata_q;
                BusErrM   = err_q;
            end
            default: ;
        endcase
    end

    assign RegWriteOutM = RegWriteM & ~StallM & ~AlignErrM & ~BusErrM;

    // Port registers are held in REQ; ack wins over a coincident timeout.
    always_comb begin
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: if (start) begin
                req_d   = 1'b1;
                we_d    = MemWriteM;
                addr_d  = {ALUOutM[ADDR_W-1:2], 2'b00};
                wdata_d = WriteDataM;
                cnt_d   = '0;
            end
            REQ: begin
                if (mem_ack) begin
                    rdata_d = we_q ? '0 : mem_rdata;
                    req_d   = 1'b0;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    err_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule : mem_access_stage

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus queues expected requests and
// completions, a negedge monitor checks them as the DUT presents them.
module tb_mem_access_stage;

    localparam int TO = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM, RegWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic        RegWriteOutM;
    logic [31:0] ReadDataM;
    logic        StallM, AlignErrM, BusErrM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .MemReadM     (MemReadM),
        .MemWriteM    (MemWriteM),
        .RegWriteM    (RegWriteM),
        .ALUOutM      (ALUOutM),
        .WriteDataM   (WriteDataM),
        .RegWriteOutM (RegWriteOutM),
        .ReadDataM    (ReadDataM),
        .StallM       (StallM),
        .AlignErrM    (AlignErrM),
        .BusErrM      (BusErrM),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          len;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        buserr;
        logic        rw;
        int          stall;
    } resp_t;

    req_t  exp_req[$];
    resp_t exp_resp[$];
    int    align_pending = 0;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    initial begin : monitor
        req_t  cur;
        resp_t r;
        logic  in_req;
        int    req_len, stall_cnt;
        in_req = 1'b0;
        req_len = 0;
        stall_cnt = 0;
        cur = '{addr: '0, we: 1'b0, wdata: '0, len: 0};
        forever begin
            @(negedge clk);
            if (reset) begin
                in_req    = 1'b0;
                stall_cnt = 0;
            end else begin
                if (mem_req && !in_req) begin
                    check("req_expected", 32'(exp_req.size() != 0), 32'd1);
                    if (exp_req.size() != 0) cur = exp_req.pop_front();
                    in_req  = 1'b1;
                    req_len = 0;
                end
                if (mem_req) begin
                    req_len++;
                    check("mem_addr",  mem_addr,        cur.addr);
                    check("mem_we",    32'(mem_we),     32'(cur.we));
                    check("mem_wdata", mem_wdata,       cur.wdata);
                end else if (in_req) begin
                    check("req_len", 32'(req_len), 32'(cur.len));
                    in_req = 1'b0;
                end

                if (StallM) begin
                    stall_cnt++;
                    check("rw_in_stall", 32'(RegWriteOutM), 32'd0);
                end else if (stall_cnt > 0) begin
                    check("resp_expected", 32'(exp_resp.size() != 0), 32'd1);
                    if (exp_resp.size() != 0) begin
                        r = exp_resp.pop_front();
                        check("ReadDataM",    ReadDataM,            r.rdata);
                        check("BusErrM",      32'(BusErrM),         32'(r.buserr));
                        check("RegWriteOutM", 32'(RegWriteOutM),    32'(r.rw));
                        check("stall_len",    32'(stall_cnt),       32'(r.stall));
                    end
                    stall_cnt = 0;
                end

                if (AlignErrM) begin
                    check("align_expected", 32'(align_pending != 0), 32'd1);
                    if (align_pending != 0) align_pending--;
                    check("align_stall", 32'(StallM),       32'd0);
                    check("align_rw",    32'(RegWriteOutM), 32'd0);
                    check("align_req",   32'(mem_req),      32'd0);
                end
            end
        end
    end

    task automatic clear_ctrl();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        RegWriteM  = 1'b0;
        ALUOutM    = '0;
        WriteDataM = '0;
        mem_ack    = 1'b0;
    endtask

    // Called at posedge+1 in IDLE; ack_at = REQ cycle carrying mem_ack (<=0: never).
    task automatic access(input logic rd, input logic wr, input logic rw,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int ack_at, input logic [31:0] rdata);
        logic err;
        int   nreq;
        MemReadM   = rd;
        MemWriteM  = wr;
        RegWriteM  = rw;
        ALUOutM    = addr;
        WriteDataM = wdata;
        mem_ack    = 1'b0;
        if (addr[1:0] != 2'b00) begin
            align_pending++;
            @(posedge clk); #1;
            clear_ctrl();
            return;
        end
        err  = !(ack_at > 0 && ack_at <= TO);
        nreq = err ? TO : ack_at;
        exp_req.push_back('{addr: {addr[31:2], 2'b00}, we: wr, wdata: wdata, len: nreq});
        exp_resp.push_back('{rdata: (rd && !err) ? rdata : 32'h0, buserr: err,
                             rw: rw && !err, stall: nreq + 1});
        @(posedge clk); #1;
        for (int k = 1; k <= nreq; k++) begin
            mem_ack   = (k == ack_at);
            mem_rdata = (k == ack_at) ? rdata : (32'hBAD0_0000 | 32'(k));
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        @(posedge clk); #1;
        clear_ctrl();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset     = 1'b1;
        mem_rdata = '0;
        clear_ctrl();
        @(negedge clk);
        check("rst_mem_req",   32'(mem_req),      32'd0);
        check("rst_mem_we",    32'(mem_we),       32'd0);
        check("rst_mem_addr",  mem_addr,          32'd0);
        check("rst_mem_wdata", mem_wdata,         32'd0);
        check("rst_ReadDataM", ReadDataM,         32'd0);
        check("rst_StallM",    32'(StallM),       32'd0);
        check("rst_AlignErrM", 32'(AlignErrM),    32'd0);
        check("rst_BusErrM",   32'(BusErrM),      32'd0);
        check("rst_RegWrOut",  32'(RegWriteOutM), 32'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        RegWriteM = 1'b1;
        @(negedge clk);
        check("idle_RegWrOut", 32'(RegWriteOutM), 32'd1);
        check("idle_StallM",   32'(StallM),       32'd0);
        @(posedge clk); #1;
        clear_ctrl();

        access(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0,          1,  32'hDEAD_BEEF);
        access(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678,  5,  32'h5555_AAAA);
        access(1'b1, 1'b0, 1'b1, 32'h0000_0013, 32'h0,          1,  32'h0);
        access(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0,          0,  32'h0);
        access(1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'h0,          TO, 32'hCAFE_F00D);
        access(1'b1, 1'b0, 1'b1, 32'h0000_0080, 32'h0,          1,  32'h0BAD_F00D);
        access(1'b0, 1'b1, 1'b0, 32'h0000_0086, 32'h7777_7777,  1,  32'h0);
        access(1'b0, 1'b1, 1'b0, 32'h0000_0084, 32'hA5A5_5A5A,  2,  32'h1111_1111);

        // Reset asserted between edges while the access sits in REQ.
        MemReadM  = 1'b1;
        RegWriteM = 1'b1;
        ALUOutM   = 32'h0000_0100;
        exp_req.push_back('{addr: 32'h0000_0100, we: 1'b0, wdata: 32'h0, len: 0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        check("rst_mid_req", 32'(mem_req), 32'd0);
        clear_ctrl();
        #1;
        check("rst_mid_state_idle", 32'(StallM), 32'd0);
        @(negedge clk); #2 reset = 1'b0;
        @(posedge clk); #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_req",   32'(mem_req), 32'd0);
        check("late_ack_rdata", ReadDataM,    32'd0);
        check("late_ack_stall", 32'(StallM),  32'd0);
        check("late_ack_buserr", 32'(BusErrM), 32'd0);
        @(posedge clk); #1;

        access(1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h0, 3, 32'h0102_0304);

        repeat (3) @(posedge clk);
        #1;
        check("req_queue_drained",  32'(exp_req.size()),  32'd0);
        check("resp_queue_drained", 32'(exp_resp.size()), 32'd0);
        check("align_drained",      32'(align_pending),   32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_access_stage
